branch_redirect_ctrl: RTL and testbench

//  Sequences the front-end after branch resolution in EX. Consumes the branch unit's
//  pc_select decision (static predict-not-taken), redirects fetch to the target via a

---
 rtl/branch_pkg.sv | 36 +++
 rtl/branch_redirect_ctrl_if.sv | 26 ++
 rtl/sat_counter.sv | 22 ++
 rtl/branch_redirect_ctrl.sv | 158 +++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch redirect controller.
//   XLEN_DEFAULT      default address width
//   BJ_*              branch/jump codes carried with the EX instruction
//   redirect_state_t  controller state (exposed on the debug output)
//   bj_is_control()   1 when a code names a real branch or jump
package branch_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] BJ_BEQ  = 3'b000;
  localparam logic [2:0] BJ_BNE  = 3'b001;
  localparam logic [2:0] BJ_NONE = 3'b010;
  localparam logic [2:0] BJ_JUMP = 3'b011;
  localparam logic [2:0] BJ_BLT  = 3'b100;
  localparam logic [2:0] BJ_BGE  = 3'b101;
  localparam logic [2:0] BJ_BLTU = 3'b110;
  localparam logic [2:0] BJ_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_REFILL   = 2'd2
  } redirect_state_t;

  // Every code except BJ_NONE is a control-flow instruction.
  function automatic logic bj_is_control(input logic [2:0] bj);
    logic r;
    case (bj)
      BJ_BEQ, BJ_BNE, BJ_BLT, BJ_BGE,
      BJ_BLTU, BJ_BGEU, BJ_JUMP: r = 1'b1;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Redirect handshake between the branch redirect controller and fetch.
//   redirect_valid  controller -> fetch, request pending
//   redirect_pc     controller -> fetch, target, stable while redirect_valid
//   redirect_ready  fetch -> controller, target accepted this cycle
// Handshake: a transfer happens on a rising edge where redirect_valid and
// redirect_ready are both 1; once raised, redirect_valid and redirect_pc stay
// unchanged until that transfer; redirect_ready may toggle freely.
interface branch_redirect_ctrl_if #(
  parameter int XLEN = branch_pkg::XLEN_DEFAULT
);
  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output redirect_valid,
    output redirect_pc,
    input  redirect_ready
  );

  modport slave (
    input  redirect_valid,
    input  redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones.
//   clk, rst  clock, synchronous active-high reset (clears count)
//   inc       increment request
//   count     current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Front-end sequencer after branch resolution in EX (static predict-not-taken).
// A taken branch/jump seen in IDLE squashes IF/ID and ID/EX in the same cycle,
// then a registered redirect request is held to fetch until accepted, then
// REFILL_CYCLES bubbles are pushed into ID/EX. Saturating statistics count
// resolved and taken branches.
//   clk, rst           clock, synchronous active-high reset
//   ex_valid           EX holds a valid instruction
//   ex_branch_jump     branch/jump code of the EX instruction
//   ex_pc_select       1 = taken / jump
//   ex_target          computed target
//   rdr                redirect handshake (master side)
//   flush_if_id        squash IF/ID
//   flush_id_ex        squash ID/EX (bubble)
//   stall_pc           hold PC, no sequential fetch
//   busy               state != IDLE
//   branch_count       resolved branch/jump count (saturating)
//   taken_count        taken branch/jump count (saturating)
//   state_dbg          current controller state
module branch_redirect_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN          = XLEN_DEFAULT,
  parameter int REFILL_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_valid,
  input  logic [2:0]             ex_branch_jump,
  input  logic                   ex_pc_select,
  input  logic [XLEN-1:0]        ex_target,
  branch_redirect_ctrl_if.master rdr,
  output logic                   flush_if_id,
  output logic                   flush_id_ex,
  output logic                   stall_pc,
  output logic                   busy,
  output logic [CNT_W-1:0]       branch_count,
  output logic [CNT_W-1:0]       taken_count,
  output redirect_state_t        state_dbg
);

  // Refill counter holds REFILL_CYCLES-1 down to 0.
  localparam int RC_W = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
  localparam logic [RC_W-1:0] REFILL_LOAD =
    RC_W'((REFILL_CYCLES > 0) ? (REFILL_CYCLES - 1) : 0);

  redirect_state_t state, state_nxt;
  logic            rv_q, rv_nxt;
  logic [XLEN-1:0] pc_q, pc_nxt;
  logic [RC_W-1:0] refill_cnt, refill_cnt_nxt;
  logic            count_branch, count_taken;
  logic            is_branch;

  assign is_branch = ex_valid && bj_is_control(ex_branch_jump);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rv_q       <= 1'b0;
      pc_q       <= '0;
      refill_cnt <= '0;
    end else begin
      state      <= state_nxt;
      rv_q       <= rv_nxt;
      pc_q       <= pc_nxt;
      refill_cnt <= refill_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    rv_nxt         = rv_q;
    pc_nxt         = pc_q;
    refill_cnt_nxt = refill_cnt;
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    stall_pc       = 1'b0;
    count_branch   = 1'b0;
    count_taken    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (is_branch) begin
          count_branch = 1'b1;
          if (ex_pc_select) begin
            // Mealy squash: the wrong-path instructions behind the branch
            // are killed in the very cycle the branch resolves.
            count_taken = 1'b1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            pc_nxt      = ex_target;
            rv_nxt      = 1'b1;
            state_nxt   = ST_REDIRECT;
          end
        end
      end

      ST_REDIRECT: begin
        // Everything fetched while waiting is wrong-path; keep squashing.
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        stall_pc    = 1'b1;
        if (rv_q && rdr.redirect_ready) begin
          rv_nxt = 1'b0;
          if (REFILL_CYCLES == 0) begin
            state_nxt = ST_IDLE;
          end else begin
            refill_cnt_nxt = REFILL_LOAD;
            state_nxt      = ST_REFILL;
          end
        end
      end

      ST_REFILL: begin
        flush_id_ex = 1'b1;
        if (refill_cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          refill_cnt_nxt = refill_cnt - RC_W'(1);
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        rv_nxt    = 1'b0;
      end
    endcase

    // Reset wins over anything EX presents in the same cycle.
    if (rst) begin
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      stall_pc     = 1'b0;
      count_branch = 1'b0;
      count_taken  = 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (count_branch),
    .count (branch_count)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (count_taken),
    .count (taken_count)
  );

  assign rdr.redirect_valid = rv_q;
  assign rdr.redirect_pc    = pc_q;
  assign busy               = (state != ST_IDLE);
  assign state_dbg          = state;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;
  import branch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ex_valid;
  logic [2:0]  ex_bj;
  logic        ex_sel;
  logic [31:0] ex_target;
  logic        ready;

  // Instance 0: default parameters. Instance 1: CNT_W=4, REFILL_CYCLES=0.
  branch_redirect_ctrl_if #(.XLEN(32)) if_a ();
  branch_redirect_ctrl_if #(.XLEN(32)) if_b ();
  assign if_a.redirect_ready = ready;
  assign if_b.redirect_ready = ready;

  logic            fif[2], fie[2], stl[2], bsy[2];
  redirect_state_t st[2];
  logic [15:0]     br_a, tk_a;
  logic [3:0]      br_b, tk_b;

  branch_redirect_ctrl #(.XLEN(32), .REFILL_CYCLES(2), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_branch_jump(ex_bj),
    .ex_pc_select(ex_sel), .ex_target(ex_target), .rdr(if_a),
    .flush_if_id(fif[0]), .flush_id_ex(fie[0]), .stall_pc(stl[0]),
    .busy(bsy[0]), .branch_count(br_a), .taken_count(tk_a), .state_dbg(st[0])
  );

  branch_redirect_ctrl #(.XLEN(32), .REFILL_CYCLES(0), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_branch_jump(ex_bj),
    .ex_pc_select(ex_sel), .ex_target(ex_target), .rdr(if_b),
    .flush_if_id(fif[1]), .flush_id_ex(fie[1]), .stall_pc(stl[1]),
    .busy(bsy[1]), .branch_count(br_b), .taken_count(tk_b), .state_dbg(st[1])
  );

  // ---------------- reference model ----------------
  // Per instance: is a redirect outstanding, how many bubble cycles remain,
  // the target, and plain integer statistics clamped at the counter maximum.
  int          refill_len[2] = '{2, 0};
  int          cnt_max[2]    = '{65535, 15};
  bit          m_wait[2];
  int          m_bub[2];
  logic [31:0] m_pc[2];
  int          m_br[2], m_tk[2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic v, input logic [2:0] bj,
                       input logic sel, input logic [31:0] tgt, input logic rdy);
    rst = r; ex_valid = v; ex_bj = bj; ex_sel = sel; ex_target = tgt; ready = rdy;
  endtask

  // Compare both instances against the model at the falling edge.
  task automatic sample();
    logic        idle_now, taking, e_busy;
    logic [31:0] a_rv, a_pc, a_br, a_tk;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      idle_now = !m_wait[k] && (m_bub[k] == 0);
      taking   = idle_now && ex_valid && (ex_bj != BJ_NONE) && ex_sel;
      e_busy   = !idle_now;
      a_rv = (k == 0) ? 32'(if_a.redirect_valid) : 32'(if_b.redirect_valid);
      a_pc = (k == 0) ? if_a.redirect_pc : if_b.redirect_pc;
      a_br = (k == 0) ? 32'(br_a) : 32'(br_b);
      a_tk = (k == 0) ? 32'(tk_a) : 32'(tk_b);
      check($sformatf("i%0d redirect_valid", k), a_rv, 32'(m_wait[k]));
      check($sformatf("i%0d redirect_pc", k), a_pc, m_pc[k]);
      check($sformatf("i%0d flush_if_id", k), 32'(fif[k]), 32'((m_wait[k] || taking) && !rst));
      check($sformatf("i%0d flush_id_ex", k), 32'(fie[k]), 32'((e_busy || taking) && !rst));
      check($sformatf("i%0d stall_pc", k), 32'(stl[k]), 32'(m_wait[k] && !rst));
      check($sformatf("i%0d busy", k), 32'(bsy[k]), 32'(e_busy));
      check($sformatf("i%0d state_dbg busy", k), 32'(st[k] != ST_IDLE), 32'(e_busy));
      check($sformatf("i%0d branch_count", k), a_br, 32'(m_br[k]));
      check($sformatf("i%0d taken_count", k), a_tk, 32'(m_tk[k]));
    end
  endtask

  // Advance the model across the rising edge, then step to just after it.
  task automatic advance();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_wait[k] = 1'b0; m_bub[k] = 0; m_pc[k] = '0; m_br[k] = 0; m_tk[k] = 0;
      end else if (m_wait[k]) begin
        if (ready) begin
          m_wait[k] = 1'b0;
          m_bub[k]  = refill_len[k];
        end
      end else if (m_bub[k] > 0) begin
        m_bub[k]--;
      end else if (ex_valid && ex_bj != BJ_NONE) begin
        if (m_br[k] < cnt_max[k]) m_br[k]++;
        if (ex_sel) begin
          if (m_tk[k] < cnt_max[k]) m_tk[k]++;
          m_pc[k]   = ex_target;
          m_wait[k] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table (instance 0) ----------------
  typedef struct {
    logic        r, v;
    logic [2:0]  bj;
    logic        sel;
    logic [31:0] tgt;
    logic        rdy;
    logic        rv;
    logic [31:0] pc;
    logic        fif, fie, stl, bsy;
    logic [15:0] br, tk;
  } vec_t;

  vec_t tbl[11];

  initial begin
    //            r  v  bj       sel tgt       rdy  rv pc      fif fie stl bsy br tk
    tbl[0]  = '{1'b1, 1'b1, BJ_JUMP, 1'b1, 32'h55,  1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[1]  = '{1'b1, 1'b1, BJ_JUMP, 1'b1, 32'h55,  1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[2]  = '{1'b0, 1'b1, BJ_BEQ,  1'b0, 32'h40,  1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[3]  = '{1'b0, 1'b1, BJ_BEQ,  1'b0, 32'h44,  1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0};
    tbl[4]  = '{1'b0, 1'b1, BJ_BEQ,  1'b0, 32'h48,  1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 16'd0};
    tbl[5]  = '{1'b0, 1'b0, BJ_NONE, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 16'd0};
    tbl[6]  = '{1'b0, 1'b1, BJ_BNE,  1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 16'd0};
    tbl[7]  = '{1'b0, 1'b0, BJ_NONE, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 1'b1, 16'd4, 16'd1};
    tbl[8]  = '{1'b0, 1'b1, BJ_JUMP, 1'b1, 32'h999, 1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 1'b0, 1'b1, 16'd4, 16'd1};
    tbl[9]  = '{1'b0, 1'b1, BJ_BEQ,  1'b0, 32'h0,   1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 1'b0, 1'b1, 16'd4, 16'd1};
    tbl[10] = '{1'b0, 1'b0, BJ_NONE, 1'b0, 32'h0,   1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 16'd1};
  end

  // ---------------- test sequence ----------------
  initial begin
    logic        r, v, s, rd;
    logic [2:0]  bj;

    for (int k = 0; k < 2; k++) begin
      m_wait[k] = 1'b0; m_bub[k] = 0; m_pc[k] = '0; m_br[k] = 0; m_tk[k] = 0;
    end
    drive(1'b1, 1'b1, BJ_JUMP, 1'b1, 32'h55, 1'b1);
    advance();

    // Reset, not-taken BEQs, taken BNE with refill
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].bj, tbl[i].sel, tbl[i].tgt, tbl[i].rdy);
      sample();
      check($sformatf("vec%0d redirect_valid", i), 32'(if_a.redirect_valid), 32'(tbl[i].rv));
      check($sformatf("vec%0d redirect_pc", i), if_a.redirect_pc, tbl[i].pc);
      check($sformatf("vec%0d flush_if_id", i), 32'(fif[0]), 32'(tbl[i].fif));
      check($sformatf("vec%0d flush_id_ex", i), 32'(fie[0]), 32'(tbl[i].fie));
      check($sformatf("vec%0d stall_pc", i), 32'(stl[0]), 32'(tbl[i].stl));
      check($sformatf("vec%0d busy", i), 32'(bsy[0]), 32'(tbl[i].bsy));
      check($sformatf("vec%0d branch_count", i), 32'(br_a), 32'(tbl[i].br));
      check($sformatf("vec%0d taken_count", i), 32'(tk_a), 32'(tbl[i].tk));
      advance();
    end

    // Jump with fetch not ready for 5 cycles; wrong-path branches ignored
    drive(1'b1, 1'b0, BJ_NONE, 1'b0, 32'h0, 1'b0); sample(); advance();
    drive(1'b0, 1'b1, BJ_JUMP, 1'b1, 32'h200, 1'b0); sample(); advance();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, BJ_BNE, 1'b1, 32'hdead, 1'b0);
      sample();
      check("wait redirect_valid", 32'(if_a.redirect_valid), 32'd1);
      check("wait redirect_pc", if_a.redirect_pc, 32'h200);
      check("wait stall_pc", 32'(stl[0]), 32'd1);
      check("wait flush_if_id", 32'(fif[0]), 32'd1);
      check("wait taken_count", 32'(tk_a), 32'd1);
      advance();
    end
    drive(1'b0, 1'b0, BJ_NONE, 1'b0, 32'h0, 1'b1); sample(); advance();
    drive(1'b0, 1'b0, BJ_NONE, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin sample(); advance(); end
    sample();
    check("after wait branch_count", 32'(br_a), 32'd1);
    check("after wait busy", 32'(bsy[0]), 32'd0);
    advance();

    // Saturation: back-to-back taken jumps, fetch always ready
    drive(1'b1, 1'b0, BJ_NONE, 1'b0, 32'h0, 1'b1); sample(); advance();
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b1, BJ_JUMP, 1'b1, 32'h1000 + 32'(i * 4), 1'b1);
      sample(); advance();
    end
    drive(1'b0, 1'b0, BJ_NONE, 1'b0, 32'h0, 1'b1);
    sample();
    check("sat branch_count", 32'(br_b), 32'd15);
    check("sat taken_count", 32'(tk_b), 32'd15);
    check("nosat branch_count", 32'(br_a), 32'd10);
    advance();

    // Reset in REDIRECT
    drive(1'b1, 1'b0, BJ_NONE, 1'b0, 32'h0, 1'b0); sample(); advance();
    drive(1'b0, 1'b1, BJ_JUMP, 1'b1, 32'h300, 1'b0); sample(); advance();
    drive(1'b0, 1'b0, BJ_NONE, 1'b0, 32'h0, 1'b0); sample();
    check("pre-rst state", 32'(st[0]), 32'(ST_REDIRECT));
    advance();
    drive(1'b1, 1'b1, BJ_JUMP, 1'b1, 32'h0, 1'b0); sample(); advance();
    drive(1'b0, 1'b0, BJ_NONE, 1'b0, 32'h0, 1'b0); sample();
    check("rst redirect valid", 32'(if_a.redirect_valid), 32'd0);
    check("rst redirect state", 32'(st[0]), 32'(ST_IDLE));
    check("rst redirect count", 32'(tk_a), 32'd0);
    advance();

    // Reset in REFILL; zero-refill instance returns straight to IDLE
    drive(1'b0, 1'b1, BJ_JUMP, 1'b1, 32'h400, 1'b1); sample(); advance();
    drive(1'b0, 1'b0, BJ_NONE, 1'b0, 32'h0, 1'b1); sample(); advance();
    drive(1'b1, 1'b0, BJ_NONE, 1'b0, 32'h0, 1'b0); sample();
    check("refill state", 32'(st[0]), 32'(ST_REFILL));
    check("zero refill idle", 32'(st[1]), 32'(ST_IDLE));
    advance();
    drive(1'b0, 1'b0, BJ_NONE, 1'b0, 32'h0, 1'b0); sample();
    check("rst refill state", 32'(st[0]), 32'(ST_IDLE));
    check("rst refill branch_count", 32'(br_a), 32'd0);
    check("rst refill redirect_pc", if_a.redirect_pc, 32'h0);
    advance();

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 63) == 0);
      v  = ($urandom_range(0, 3) != 0);
      bj = 3'($urandom_range(0, 7));
      s  = (bj == BJ_JUMP) ? 1'b1 : 1'($urandom_range(0, 1));
      rd = ($urandom_range(0, 2) != 0);
      drive(r, v, bj, s, $urandom, rd);
      sample();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
